// File: rtl/switch_allocator.sv
// switch_allocator: per-output round-robin switch allocator with wormhole locks.
// Allocation is combinational from the current requests and the registered
// lock/pointer state. DROP requests are granted with no output driven.
module switch_allocator #(
    parameter int NUM_PORTS = 7
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_PORTS-1:0]   req_valid,
    input  logic [NUM_PORTS*3-1:0] req_port,
    input  logic [NUM_PORTS-1:0]   req_tail,
    input  logic [NUM_PORTS-1:0]   out_ready,
    output logic [NUM_PORTS-1:0]   grant,
    output logic [NUM_PORTS-1:0]   xbar_valid,
    output logic [NUM_PORTS*3-1:0] xbar_sel
);

    localparam logic [2:0] PORT_DROP = 3'd7;
    localparam logic [2:0] LAST_PORT = 3'(NUM_PORTS - 1);

    // Unpacked view of the per-input target port
    logic [2:0]           port_of [NUM_PORTS];

    // Per-output state
    logic [NUM_PORTS-1:0] lock_vld;
    logic [2:0]           lock_in [NUM_PORTS];
    logic [2:0]           rr_ptr  [NUM_PORTS];

    // Per-output arbitration result
    logic [NUM_PORTS-1:0] win_vld;
    logic [2:0]           win_in  [NUM_PORTS];
    logic [NUM_PORTS-1:0] xfer;

    // Round-robin scan helpers
    logic [3:0]           scan_sum;
    logic [2:0]           scan_idx;

    // Split the packed request port bus into one 3-bit target per input
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_of[i] = req_port[i*3 +: 3];
        end
    end

    // Pick a winner per output: the lock owner when locked, otherwise the first
    // requester at or after the round-robin pointer
    always_comb begin
        // NOTE: every variable gets a default before any conditional update so
        // no path leaves it unassigned, which would otherwise infer a latch.
        win_vld  = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            win_in[o] = '0;
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (lock_vld[o]) begin
                if (req_valid[lock_in[o]] && port_of[lock_in[o]] == 3'(o)) begin
                    win_vld[o] = 1'b1;
                    win_in[o]  = lock_in[o];
                end
            end else begin
                for (int k = 0; k < NUM_PORTS; k++) begin
                    scan_sum = {1'b0, rr_ptr[o]} + 4'(k);
                    if (scan_sum >= 4'(NUM_PORTS)) begin
                        scan_sum = scan_sum - 4'(NUM_PORTS);
                    end
                    scan_idx = scan_sum[2:0];
                    if (!win_vld[o] && req_valid[scan_idx] && port_of[scan_idx] == 3'(o)) begin
                        win_vld[o] = 1'b1;
                        win_in[o]  = scan_idx;
                    end
                end
            end
        end
    end

    // Drive grants and crossbar selects; everything is held at zero during reset
    always_comb begin
        grant      = '0;
        xbar_valid = '0;
        xbar_sel   = '0;
        xfer       = '0;
        if (!rst) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (req_valid[i] && port_of[i] == PORT_DROP) begin
                    grant[i] = 1'b1;
                end
            end
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (win_vld[o] && out_ready[o]) begin
                    xfer[o]              = 1'b1;
                    xbar_valid[o]        = 1'b1;
                    xbar_sel[o*3 +: 3]   = win_in[o];
                    grant[win_in[o]]     = 1'b1;
                end
            end
        end
    end

    // Update locks and pointers on each transfer; pointer advances only on tails
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every output's
        // update sees the same pre-edge values regardless of statement order.
        if (rst) begin
            lock_vld <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                lock_in[o] <= '0;
                rr_ptr[o]  <= '0;
            end
        end else begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (xfer[o]) begin
                    if (req_tail[win_in[o]]) begin
                        lock_vld[o] <= 1'b0;
                        rr_ptr[o]   <= (win_in[o] == LAST_PORT) ? 3'd0 : win_in[o] + 3'd1;
                    end else begin
                        lock_vld[o] <= 1'b1;
                        lock_in[o]  <= win_in[o];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Testbench for switch_allocator: directed vector table, hand-written lock and
// reset sequences, and sticky-port random traffic against a behavioural model.
`timescale 1ns/1ps
module tb_switch_allocator;

    localparam int NP = 7;
    localparam int P_LOCAL = 0, P_NORTH = 1, P_EAST = 3, P_WEST = 4, P_UP = 5, P_DOWN = 6, P_DROP = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  req_valid, req_tail, out_ready;
    logic [20:0] req_port;
    logic [6:0]  grant, xbar_valid;
    logic [20:0] xbar_sel;

    always #5 clk = ~clk;

    switch_allocator #(.NUM_PORTS(NP)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_port   (req_port),
        .req_tail   (req_tail),
        .out_ready  (out_ready),
        .grant      (grant),
        .xbar_valid (xbar_valid),
        .xbar_sel   (xbar_sel)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: owner of each output's lock (-1 = none) and its pointer
    int          m_lock [NP];
    int          m_ptr  [NP];
    int          nx_lock[NP];
    int          nx_ptr [NP];
    logic [6:0]  m_grant, m_xv;
    logic [20:0] m_xs;

    logic [6:0]  cap_grant, cap_xv;
    logic [20:0] cap_xs;

    typedef struct {
        logic [6:0]  v;
        logic [20:0] p;
        logic [6:0]  t;
        logic [6:0]  rd;
        logic [6:0]  g;
        logic [6:0]  xv;
        logic [20:0] xs;
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [20:0] act, input logic [20:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [20:0] pv1(input int i, input int p);
        logic [20:0] r;
        r = '0;
        r[3*i +: 3] = 3'(p);
        return r;
    endfunction

    // Compute expected outputs and next state from the allocation rules
    task automatic model_eval(input logic r, input logic [6:0] v, input logic [20:0] p,
                              input logic [6:0] t, input logic [6:0] rd);
        int tgt[NP];
        m_grant = '0;
        m_xv    = '0;
        m_xs    = '0;
        for (int o = 0; o < NP; o++) begin
            nx_lock[o] = m_lock[o];
            nx_ptr[o]  = m_ptr[o];
        end
        if (r) begin
            for (int o = 0; o < NP; o++) begin
                nx_lock[o] = -1;
                nx_ptr[o]  = 0;
            end
            return;
        end
        for (int i = 0; i < NP; i++) begin
            tgt[i] = int'(p[3*i +: 3]);
            if (v[i] && tgt[i] == P_DROP) m_grant[i] = 1'b1;
        end
        for (int o = 0; o < NP; o++) begin
            int win;
            int best;
            win  = -1;
            best = NP;
            if (m_lock[o] >= 0) begin
                if (v[m_lock[o]] && tgt[m_lock[o]] == o) win = m_lock[o];
            end else begin
                for (int i = 0; i < NP; i++) begin
                    if (v[i] && tgt[i] == o && ((i - m_ptr[o] + NP) % NP) < best) begin
                        best = (i - m_ptr[o] + NP) % NP;
                        win  = i;
                    end
                end
            end
            if (win >= 0 && rd[o]) begin
                m_grant[win]   = 1'b1;
                m_xv[o]        = 1'b1;
                m_xs[3*o +: 3] = 3'(win);
                if (t[win]) begin
                    nx_lock[o] = -1;
                    nx_ptr[o]  = (win + 1) % NP;
                end else begin
                    nx_lock[o] = win;
                end
            end
        end
    endtask

    // One clock cycle: drive on negedge, sample and compare to model, commit at posedge
    task automatic cyc(input logic r, input logic [6:0] v, input logic [20:0] p,
                       input logic [6:0] t, input logic [6:0] rd);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_port  = p;
        req_tail  = t;
        out_ready = rd;
        #1;
        cap_grant = grant;
        cap_xv    = xbar_valid;
        cap_xs    = xbar_sel;
        model_eval(r, v, p, t, rd);
        check($sformatf("model grant t=%0t", $time), 21'(cap_grant), 21'(m_grant));
        check($sformatf("model xbar_valid t=%0t", $time), 21'(cap_xv), 21'(m_xv));
        check($sformatf("model xbar_sel t=%0t", $time), cap_xs, m_xs);
        @(posedge clk);
        for (int o = 0; o < NP; o++) begin
            m_lock[o] = nx_lock[o];
            m_ptr[o]  = nx_ptr[o];
        end
    endtask

    task automatic chk_g(input string name, input logic [6:0] g, input logic [6:0] xv);
        check({name, " grant"}, 21'(cap_grant), 21'(g));
        check({name, " xbar_valid"}, 21'(cap_xv), 21'(xv));
    endtask

    task automatic do_reset();
        cyc(1'b1, 7'h00, 21'h0, 7'h00, 7'h7F);
    endtask

    initial begin
        logic [6:0]  v, t, rd;
        logic [20:0] p;
        int          cur_port[NP];

        rst = 1'b1; req_valid = '0; req_port = '0; req_tail = '0; out_ready = '0;
        for (int o = 0; o < NP; o++) begin
            m_lock[o] = -1;
            m_ptr[o]  = 0;
        end

        // Reset with live requests: outputs must be forced to zero
        cyc(1'b1, 7'h7F, pv1(0, P_EAST) | pv1(3, P_DROP), 7'h7F, 7'h7F);
        check("reset grant", 21'(cap_grant), 21'h0);
        check("reset xbar_valid", 21'(cap_xv), 21'h0);
        check("reset xbar_sel", cap_xs, 21'h0);

        // Directed vector table, run from reset state
        tbl[0] = '{7'b0000001, pv1(0, P_EAST), 7'h7F, 7'h7F, 7'b0000001, 7'b0001000, 21'h0};
        tbl[1] = '{7'b0000011, pv1(0, P_EAST) | pv1(1, P_EAST), 7'h7F, 7'h7F,
                   7'b0000010, 7'b0001000, pv1(P_EAST, 1)};
        for (int k = 2; k < 6; k++) begin
            tbl[k] = '{7'b0010110, pv1(1, P_NORTH) | pv1(2, P_NORTH) | pv1(4, P_NORTH),
                       7'h7F, 7'h7F, 7'b0, 7'b0000010, 21'h0};
        end
        tbl[2].g = 7'b0000010; tbl[2].xs = pv1(P_NORTH, 1);
        tbl[3].g = 7'b0000100; tbl[3].xs = pv1(P_NORTH, 2);
        tbl[4].g = 7'b0010000; tbl[4].xs = pv1(P_NORTH, 4);
        tbl[5].g = 7'b0000010; tbl[5].xs = pv1(P_NORTH, 1);
        tbl[6] = '{7'b0101001, pv1(0, P_LOCAL) | pv1(3, P_DROP) | pv1(5, P_DOWN), 7'h7F, 7'h7F,
                   7'b0101001, 7'b1000001, pv1(P_DOWN, 5)};
        tbl[7] = '{7'b0, 21'h0, 7'h7F, 7'h7F, 7'b0, 7'b0, 21'h0};

        for (int k = 0; k < 8; k++) begin
            cyc(1'b0, tbl[k].v, tbl[k].p, tbl[k].t, tbl[k].rd);
            check($sformatf("tbl[%0d] grant", k), 21'(cap_grant), 21'(tbl[k].g));
            check($sformatf("tbl[%0d] xbar_valid", k), 21'(cap_xv), 21'(tbl[k].xv));
            check($sformatf("tbl[%0d] xbar_sel", k), cap_xs, tbl[k].xs);
        end

        // 3-flit packet in2 -> UP competing with in5; in5 wins after the tail
        do_reset();
        p = pv1(2, P_UP) | pv1(5, P_UP);
        cyc(1'b0, 7'b0100100, p, 7'b0100000, 7'h7F); chk_g("pkt head", 7'b0000100, 7'b0100000);
        cyc(1'b0, 7'b0100100, p, 7'b0100000, 7'h7F); chk_g("pkt body", 7'b0000100, 7'b0100000);
        cyc(1'b0, 7'b0100100, p, 7'b0100100, 7'h7F); chk_g("pkt tail", 7'b0000100, 7'b0100000);
        cyc(1'b0, 7'b0100100, p, 7'b0100100, 7'h7F); chk_g("pkt after", 7'b0100000, 7'b0100000);

        // Lock owner bubbles for two cycles: UP idle, in5 blocked
        do_reset();
        cyc(1'b0, 7'b0100100, p, 7'b0100000, 7'h7F); chk_g("bub head", 7'b0000100, 7'b0100000);
        cyc(1'b0, 7'b0100000, p, 7'b0100000, 7'h7F); chk_g("bub gap1", 7'b0000000, 7'b0000000);
        cyc(1'b0, 7'b0100000, p, 7'b0100000, 7'h7F); chk_g("bub gap2", 7'b0000000, 7'b0000000);
        cyc(1'b0, 7'b0100100, p, 7'b0100100, 7'h7F); chk_g("bub tail", 7'b0000100, 7'b0100000);
        cyc(1'b0, 7'b0100000, p, 7'b0100100, 7'h7F); chk_g("bub in5", 7'b0100000, 7'b0100000);

        // Stalled WEST: no grant and no lock until out_ready rises
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 7'b1000000, pv1(6, P_WEST), 7'b0, 7'b1101111);
            chk_g($sformatf("stall %0d", k), 7'b0, 7'b0);
        end
        cyc(1'b0, 7'b1000000, pv1(6, P_WEST), 7'b0, 7'h7F);
        chk_g("stall release", 7'b1000000, 7'b0010000);
        check("stall release sel", cap_xs, pv1(P_WEST, 6));
        cyc(1'b0, 7'b1000001, pv1(6, P_WEST) | pv1(0, P_WEST), 7'b1000001, 7'h7F);
        chk_g("west locked", 7'b1000000, 7'b0010000);
        cyc(1'b0, 7'b0000001, pv1(0, P_WEST), 7'b0000001, 7'h7F);
        chk_g("west in0", 7'b0000001, 7'b0010000);

        // DROP requests are consumed regardless of output readiness
        cyc(1'b0, 7'b0001000, pv1(3, P_DROP), 7'b0001000, 7'h7F); chk_g("drop 0", 7'b0001000, 7'b0);
        cyc(1'b0, 7'b0001000, pv1(3, P_DROP), 7'b0000000, 7'h00); chk_g("drop 1", 7'b0001000, 7'b0);
        cyc(1'b0, 7'b0000000, pv1(3, P_DROP), 7'b0001000, 7'h7F); chk_g("drop idle", 7'b0000000, 7'b0);

        // Reset mid-packet drops the lock; in5 wins UP right after
        do_reset();
        cyc(1'b0, 7'b0100100, p, 7'b0100000, 7'h7F); chk_g("rst head", 7'b0000100, 7'b0100000);
        cyc(1'b1, 7'b0100100, p, 7'b0100000, 7'h7F); chk_g("rst mid", 7'b0000000, 7'b0000000);
        cyc(1'b0, 7'b0100000, p, 7'b0100000, 7'h7F); chk_g("rst after", 7'b0100000, 7'b0100000);
        check("rst after sel", cap_xs, pv1(P_UP, 5));

        // Random traffic: each input keeps its target until it sends a granted tail
        for (int i = 0; i < NP; i++) cur_port[i] = int'($urandom_range(7, 0));
        for (int n = 0; n < 400; n++) begin
            logic r;
            r = ($urandom_range(99, 0) == 0);
            p = '0;
            for (int i = 0; i < NP; i++) begin
                v[i]  = ($urandom_range(9, 0) < 8);
                t[i]  = ($urandom_range(2, 0) == 0);
                rd[i] = ($urandom_range(3, 0) != 0);
                p |= pv1(i, cur_port[i]);
            end
            cyc(r, v, p, t, rd);
            for (int i = 0; i < NP; i++) begin
                if (r || (m_grant[i] && t[i])) cur_port[i] = int'($urandom_range(7, 0));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
